// File: rtl/branch_predict_resolver_if.sv
// Fetch-lookup and execute-resolve signal bundle for the branch predictor/resolver.
// Latency: none (pure wiring); the slave drives combinational and registered outputs.
// Backpressure: none; the slave accepts one resolve per clock unconditionally.
interface branch_predict_resolver_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]   fetchPc;
    logic                  predictTaken;
    logic                  exValid;
    logic                  exFlush;
    logic [PC_WIDTH-1:0]   exPc;
    logic [2:0]            branch;
    logic                  zero;
    logic                  sign;
    logic                  exPredTaken;
    logic                  branchTaken;
    logic                  mispredict;
    logic                  redirectTaken;
    logic [STAT_WIDTH-1:0] branchCount;
    logic [STAT_WIDTH-1:0] mispredictCount;

    // Resolver side
    modport slave (
        input  fetchPc, exValid, exFlush, exPc, branch, zero, sign, exPredTaken,
        output predictTaken, branchTaken, mispredict, redirectTaken,
               branchCount, mispredictCount
    );

    // Pipeline side (fetch + execute)
    modport master (
        output fetchPc, exValid, exFlush, exPc, branch, zero, sign, exPredTaken,
        input  predictTaken, branchTaken, mispredict, redirectTaken,
               branchCount, mispredictCount
    );
endinterface

// File: rtl/branch_predict_resolver.sv
// Branch condition resolve plus PC-indexed 2-bit saturating predictor table and stats.
// Latency: predictTaken/branchTaken combinational; mispredict/redirect/counts 1 clock.
// Backpressure: none; every resolving execute cycle is consumed in that cycle.
module branch_predict_resolver #(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32,
    parameter int PC_LSB     = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    branch_predict_resolver_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        SN = 2'd0,
        WN = 2'd1,
        WT = 2'd2,
        ST = 2'd3
    } ctr_t;

    ctr_t                  tbl_q [DEPTH];
    ctr_t                  ex_ctr;
    ctr_t                  ex_ctr_d;
    logic [1:0]            fetch_ctr;
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic                  taken;
    logic                  resolve;
    logic                  mispredict_q;
    logic                  redirect_q;
    logic [STAT_WIDTH-1:0] branch_cnt_q;
    logic [STAT_WIDTH-1:0] branch_cnt_d;
    logic [STAT_WIDTH-1:0] mispred_cnt_q;
    logic [STAT_WIDTH-1:0] mispred_cnt_d;
    logic                  unused_pc_bits;

    // Only a window of each PC indexes the table; the remaining bits are ignored.
    assign unused_pc_bits = ^{bus.fetchPc, bus.exPc};

    assign fetch_idx = bus.fetchPc[PC_LSB+INDEX_BITS-1:PC_LSB];
    assign ex_idx    = bus.exPc[PC_LSB+INDEX_BITS-1:PC_LSB];

    // Fetch lookup reads the registered table: no bypass of a same-cycle update.
    assign fetch_ctr        = tbl_q[fetch_idx];
    assign bus.predictTaken = fetch_ctr[1];
    assign ex_ctr           = tbl_q[ex_idx];

    // Branch condition decode from the ALU flags; independent of exValid.
    always_comb begin
        taken = 1'b0;
        case (bus.branch)
            3'd0: taken = 1'b0;
            3'd1: taken = bus.zero;
            3'd2: taken = ~bus.zero;
            3'd3: taken = ~bus.sign | bus.zero;
            3'd4: taken = ~bus.sign & ~bus.zero;
            3'd5: taken = bus.sign | bus.zero;
            3'd6: taken = bus.sign;
            default: taken = 1'b1;
        endcase
    end

    assign bus.branchTaken = taken;

    // A squashed or non-branch instruction must leave all state untouched.
    assign resolve = bus.exValid & ~bus.exFlush & (bus.branch != 3'd0);

    // Saturating 2-bit counter step toward the resolved direction.
    always_comb begin
        ex_ctr_d = ex_ctr;
        if (taken) begin
            if (ex_ctr != ST) ex_ctr_d = ctr_t'(ex_ctr + 2'd1);
        end else begin
            if (ex_ctr != SN) ex_ctr_d = ctr_t'(ex_ctr - 2'd1);
        end
    end

    // Predictor table: reset to weakly-not-taken, train on each resolve.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= WN;
        end else if (resolve) begin
            tbl_q[ex_idx] <= ex_ctr_d;
        end
    end

    // Statistics counters hold at all-ones instead of wrapping.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && (branch_cnt_q != STAT_MAX))
            branch_cnt_d = branch_cnt_q + 1'b1;
        if (resolve && (taken != bus.exPredTaken) && (mispred_cnt_q != STAT_MAX))
            mispred_cnt_d = mispred_cnt_q + 1'b1;
    end

    // One-cycle redirect pulses and registered statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_q  <= 1'b0;
            redirect_q    <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispredict_q  <= resolve & (taken != bus.exPredTaken);
            redirect_q    <= resolve & taken;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.mispredict      = mispredict_q;
    assign bus.redirectTaken   = redirect_q;
    assign bus.branchCount     = branch_cnt_q;
    assign bus.mispredictCount = mispred_cnt_q;
endmodule
